// File: rtl/sevenseg_scan_ctrl_if.sv
// Pin and data bundle for the multiplexed 7-segment scan controller.
// master drives the digit/control inputs; slave is the controller.
interface sevenseg_scan_ctrl_if #(
  parameter int N_DIGITS = 8,
  parameter int BRIGHT_W = 4
);
  logic [4*N_DIGITS-1:0] digits_in;
  logic [N_DIGITS-1:0]   dp_in;
  logic [N_DIGITS-1:0]   blank_in;
  logic [BRIGHT_W-1:0]   bright_in;
  logic [6:0]            seg;
  logic                  dp;
  logic [N_DIGITS-1:0]   an;
  logic                  frame_start;

  modport master (
    output digits_in, dp_in, blank_in, bright_in,
    input  seg, dp, an, frame_start
  );

  modport slave (
    input  digits_in, dp_in, blank_in, bright_in,
    output seg, dp, an, frame_start
  );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner with PWM dimming.
// Define SEVSEG_HEX_EN to show codes 10..15 as A b C d E F.
module sevenseg_scan_ctrl #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int REFRESH_HZ = 1_000,
  parameter int N_DIGITS   = 8,
  parameter int BRIGHT_W   = 4
) (
  input logic clock,
  input logic reset,
  sevenseg_scan_ctrl_if.slave bus
);
  localparam int SLOT = CLK_FREQ / (REFRESH_HZ * N_DIGITS);
  localparam int PW   = (SLOT < 2) ? 1 : $clog2(SLOT);
  localparam int IW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int DW   = 4 * N_DIGITS;

  if (SLOT < 2) begin : g_bad_slot
    $error("sevenseg_scan_ctrl: SLOT must be at least 2");
  end

  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [BRIGHT_W-1:0] pwm_q, pwm_d;
  logic                first_q, first_d;
  logic [DW-1:0]       dig_q, dig_d;
  logic [N_DIGITS-1:0] dpr_q, dpr_d;
  logic [N_DIGITS-1:0] blk_q, blk_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic                fs_q, fs_d;

  logic       tick, wrap, cap, pwm_on, lit;
  logic [3:0] code;

  function automatic logic [6:0] dec7(input logic [3:0] c);
    logic [6:0] s;
    case (c)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
`ifdef SEVSEG_HEX_EN
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      4'hF: s = 7'b0111000;
`endif
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Scan timing, frame capture and next pin values from current state
  always_comb begin
    tick    = (presc_q == PW'(SLOT - 1));
    wrap    = tick && (idx_q == IW'(N_DIGITS - 1));
    cap     = first_q || wrap;
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (wrap) begin
      idx_d = '0;
    end else if (tick) begin
      idx_d = idx_q + 1'b1;
    end
    pwm_d   = pwm_q + 1'b1;
    first_d = 1'b0;
    dig_d   = cap ? bus.digits_in : dig_q;
    dpr_d   = cap ? bus.dp_in : dpr_q;
    blk_d   = cap ? bus.blank_in : blk_q;
    fs_d    = cap;
    code    = dig_q[{idx_q, 2'b00} +: 4];
    pwm_on  = (pwm_q < bus.bright_in) || (&bus.bright_in);
    lit     = !first_q && !blk_q[idx_q] && pwm_on;
    an_d    = '1;
    seg_d   = 7'h7F;
    dp_d    = 1'b1;
    if (lit) begin
      an_d[idx_q] = 1'b0;
      seg_d       = dec7(code);
      dp_d        = ~dpr_q[idx_q];
    end
  end

  // State and registered pin drivers
  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      pwm_q   <= '0;
      first_q <= 1'b1;
      dig_q   <= '0;
      dpr_q   <= '0;
      blk_q   <= '0;
      an_q    <= '1;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      pwm_q   <= pwm_d;
      first_q <= first_d;
      dig_q   <= dig_d;
      dpr_q   <= dpr_d;
      blk_q   <= blk_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      fs_q    <= fs_d;
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.frame_start = fs_q;
endmodule
